vga_fill_sequencer: RTL and testbench

- Rectangle-fill command engine that drives the VGA adapter pixel write port: x_in, y_in, r_in, g_in, b_in and a plot strobe.
- Accepts one fill command per valid/ready handshake.
- Normalises and clips the rectangle, then emits one pixel per cycle in row-major order.
- Sits between the drawing/CPU logic and the VGA adapter. It is the sole sequencer of the adapter's write port.

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_rect_norm.sv | 31 +++
 rtl/vga_fill_sequencer.sv | 88 ++++++++
 tb/tb_vga_fill_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: resolution decode helpers and fill FSM state type for the VGA fill engine.
package vga_pkg;
   typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;
   function automatic int x_width(input logic [55:0] res);
      return res == "160x120" ? 8 : res == "320x240" ? 9 : 10;
   endfunction
   function automatic int y_width(input logic [55:0] res);
      return res == "160x120" ? 8 : res == "320x240" ? 8 : 9;
   endfunction
   function automatic int x_max(input logic [55:0] res);
      return res == "160x120" ? 159 : res == "320x240" ? 319 : 639;
   endfunction
   function automatic int y_max(input logic [55:0] res);
      return res == "160x120" ? 119 : res == "320x240" ? 239 : 479;
   endfunction
endpackage

// File: rtl/vga_rect_norm.sv
// vga_rect_norm: orders rectangle corners and clips the far edges to the screen.
module vga_rect_norm #(
   parameter int X_W = 10,
   parameter int Y_W = 9,
   parameter int X_MAX = 639,
   parameter int Y_MAX = 479
) (
   input  logic [X_W-1:0] x0_i,
   input  logic [X_W-1:0] x1_i,
   input  logic [Y_W-1:0] y0_i,
   input  logic [Y_W-1:0] y1_i,
   output logic [X_W-1:0] xmin_o,
   output logic [X_W-1:0] xmax_o,
   output logic [Y_W-1:0] ymin_o,
   output logic [Y_W-1:0] ymax_o,
   output logic           off_o
);
   localparam logic [X_W-1:0] XM = X_W'(X_MAX);
   localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);
   logic [X_W-1:0] xhi;
   logic [Y_W-1:0] yhi;
   always_comb begin
      xmin_o = x0_i < x1_i ? x0_i : x1_i;
      xhi    = x0_i < x1_i ? x1_i : x0_i;
      xmax_o = xhi > XM ? XM : xhi;
      ymin_o = y0_i < y1_i ? y0_i : y1_i;
      yhi    = y0_i < y1_i ? y1_i : y0_i;
      ymax_o = yhi > YM ? YM : yhi;
      off_o  = xmin_o > XM || ymin_o > YM;
   end
endmodule

// File: rtl/vga_fill_sequencer.sv
// vga_fill_sequencer: rectangle-fill engine emitting one clipped pixel per cycle
// in row-major order onto the VGA adapter write port.
module vga_fill_sequencer
   import vga_pkg::*;
#(
   parameter logic [55:0] RESOLUTION = "640x480",
   parameter int CHANNEL_SIZES = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             pll_lock,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic [x_width(RESOLUTION)-1:0]   cmd_x0,
   input  logic [x_width(RESOLUTION)-1:0]   cmd_x1,
   input  logic [y_width(RESOLUTION)-1:0]   cmd_y0,
   input  logic [y_width(RESOLUTION)-1:0]   cmd_y1,
   input  logic [CHANNEL_SIZES-1:0]         cmd_r,
   input  logic [CHANNEL_SIZES-1:0]         cmd_g,
   input  logic [CHANNEL_SIZES-1:0]         cmd_b,
   input  logic                             plot_stall,
   output logic [x_width(RESOLUTION)-1:0]   x_out,
   output logic [y_width(RESOLUTION)-1:0]   y_out,
   output logic [CHANNEL_SIZES-1:0]         r_out,
   output logic [CHANNEL_SIZES-1:0]         g_out,
   output logic [CHANNEL_SIZES-1:0]         b_out,
   output logic                             plot,
   output logic                             busy,
   output logic                             done
);
   localparam int X_W = x_width(RESOLUTION);
   localparam int Y_W = y_width(RESOLUTION);
   fill_state_t state_q, state_d;
   logic [X_W-1:0] cur_x_q, cur_x_d, xmin_q, xmax_q, n_xmin, n_xmax;
   logic [Y_W-1:0] cur_y_q, cur_y_d, ymax_q, n_ymin, n_ymax;
   logic [CHANNEL_SIZES-1:0] r_q, g_q, b_q;
   logic n_off, accept, last_x, last;
   vga_rect_norm #(
      .X_W(X_W), .Y_W(Y_W), .X_MAX(x_max(RESOLUTION)), .Y_MAX(y_max(RESOLUTION))
   ) u_norm (
      .x0_i(cmd_x0), .x1_i(cmd_x1), .y0_i(cmd_y0), .y1_i(cmd_y1),
      .xmin_o(n_xmin), .xmax_o(n_xmax), .ymin_o(n_ymin), .ymax_o(n_ymax), .off_o(n_off)
   );
   always_comb begin
      cmd_ready = state_q == IDLE && pll_lock && !rst;
      accept    = cmd_valid && cmd_ready;
      plot      = state_q == FILL && pll_lock && !plot_stall;
      last_x    = cur_x_q == xmax_q;
      last      = last_x && cur_y_q == ymax_q;
      state_d   = state_q == IDLE ? (accept ? (n_off ? DONE : FILL) : IDLE)
                : state_q == FILL ? (plot && last ? DONE : FILL) : IDLE;
      // scan position only moves on cycles that actually wrote a pixel
      cur_x_d   = accept ? n_xmin : plot ? (last_x ? xmin_q : cur_x_q + 1'b1) : cur_x_q;
      cur_y_d   = accept ? n_ymin : plot && last_x && !last ? cur_y_q + 1'b1 : cur_y_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cur_x_q <= '0;
         cur_y_q <= '0;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymax_q  <= '0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cur_x_q <= cur_x_d;
         cur_y_q <= cur_y_d;
         if (accept) begin
            xmin_q <= n_xmin;
            xmax_q <= n_xmax;
            ymax_q <= n_ymax;
            r_q    <= cmd_r;
            g_q    <= cmd_g;
            b_q    <= cmd_b;
         end
      end
   end
   assign x_out = cur_x_q;
   assign y_out = cur_y_q;
   assign r_out = r_q;
   assign g_out = g_q;
   assign b_out = b_q;
   assign busy  = state_q != IDLE;
   assign done  = state_q == DONE;
endmodule

// File: tb/tb_vga_fill_sequencer.sv
// tb_vga_fill_sequencer: directed and random fill commands checked against a
// pixel-list model of the clipped rectangle scan.
module tb_vga_fill_sequencer;
   logic clk = 0, rst = 1, pll_lock = 1, cmd_valid = 0, plot_stall = 0;
   logic cmd_ready, plot, busy, done;
   logic [9:0] cmd_x0 = 0, cmd_x1 = 0, x_out;
   logic [8:0] cmd_y0 = 0, cmd_y1 = 0, y_out;
   logic [7:0] cmd_r = 0, cmd_g = 0, cmd_b = 0, r_out, g_out, b_out;
   int n_chk = 0, n_fail = 0;

   vga_fill_sequencer #(.RESOLUTION("640x480"), .CHANNEL_SIZES(8)) dut (
      .clk(clk), .rst(rst), .pll_lock(pll_lock), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
      .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b), .plot_stall(plot_stall),
      .x_out(x_out), .y_out(y_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .plot(plot), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Issues one command and follows it cycle by cycle. stall_m/lock_m bit k
   // forces a stall / lock loss in the k-th cycle after acceptance.
   task automatic fill(input int x0, input int y0, input int x1, input int y1,
                       input logic [23:0] rgb, input logic [127:0] stall_m,
                       input logic [127:0] lock_m, input bit rnd, input int abort_after);
      logic [18:0] q[$];
      int xl, xh, yl, yh, w, plots, done_k, total;
      bit st, lk, exp_plot, finished;
      xl = x0 < x1 ? x0 : x1;
      xh = x0 < x1 ? x1 : x0;
      yl = y0 < y1 ? y0 : y1;
      yh = y0 < y1 ? y1 : y0;
      if (xh > 639) xh = 639;
      if (yh > 479) yh = 479;
      if (xl <= 639 && yl <= 479)
         for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
               q.push_back({10'(x), 9'(y)});
      total = q.size();
      cmd_x0 = 10'(x0); cmd_x1 = 10'(x1); cmd_y0 = 9'(y0); cmd_y1 = 9'(y1);
      {cmd_r, cmd_g, cmd_b} = rgb;
      pll_lock = 1; plot_stall = 0; cmd_valid = 1;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
      chk("accept_ready", {63'd0, cmd_ready}, 64'd1);
      @(posedge clk); #1;
      cmd_valid = 0;
      cmd_x0 = 10'($urandom); cmd_y0 = 9'($urandom);
      {cmd_r, cmd_g, cmd_b} = 24'($urandom);
      plots = 0; finished = 0;
      done_k = total == 0 ? 1 : -1;
      for (int k = 1; k < 4 * total + 40; k++) begin
         st = (k < 128 && stall_m[k]) || (rnd && $urandom_range(0, 3) == 0);
         lk = !((k < 128 && lock_m[k]) || (rnd && $urandom_range(0, 7) == 0));
         plot_stall = st; pll_lock = lk;
         if (abort_after > 0 && plots == abort_after) begin
            rst = 1;
            @(posedge clk); #1;
            rst = 0; plot_stall = 0; pll_lock = 1;
            @(negedge clk);
            chk("abort_plot", {63'd0, plot}, 64'd0);
            chk("abort_busy", {63'd0, busy}, 64'd0);
            chk("abort_done", {63'd0, done}, 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("abort_nodone", {63'd0, done}, 64'd0);
            finished = 1;
            break;
         end
         @(negedge clk);
         exp_plot = q.size() > 0 && lk && !st;
         chk("plot", {63'd0, plot}, {63'd0, exp_plot});
         if (exp_plot) begin
            if (plot) chk("pixel", {21'd0, x_out, y_out, r_out, g_out, b_out}, {21'd0, q[0], rgb});
            void'(q.pop_front());
            plots++;
            if (q.size() == 0) done_k = k + 1;
         end
         chk("done", {63'd0, done}, {63'd0, k == done_k});
         chk("busy", {63'd0, busy}, {63'd0, done_k < 0 || k <= done_k});
         if (done_k > 0 && k == done_k + 1) begin
            chk("ready_after", {63'd0, cmd_ready}, {63'd0, lk});
            chk("plot_count", 64'(plots), 64'(total));
            finished = 1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("finished", {63'd0, finished}, 64'd1);
      @(posedge clk); #1;
      plot_stall = 0; pll_lock = 1;
   endtask

   initial begin
      int x0, y0;
      rst = 1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_outs", {21'd0, cmd_ready, plot, busy, done, x_out, y_out, r_out, g_out, b_out}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("ready_release", {63'd0, cmd_ready}, 64'd1);
      chk("plot_release", {63'd0, plot}, 64'd0);
      @(posedge clk); #1;

      fill(5, 2, 3, 3, 24'hFF0080, '0, '0, 0, 0);
      fill(630, 470, 700, 500, 24'h123456, '0, '0, 0, 0);
      fill(2, 2, 4, 2, 24'hA5A5A5, 128'b1100, '0, 0, 0);
      fill(700, 10, 650, 20, 24'h010203, '0, '0, 0, 0);
      fill(7, 7, 7, 7, 24'h0F0F0F, '0, '0, 0, 0);

      pll_lock = 0; cmd_valid = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nolock_ready", {63'd0, cmd_ready}, 64'd0);
         chk("nolock_busy", {63'd0, busy}, 64'd0);
         @(posedge clk); #1;
      end
      fill(0, 0, 3, 1, 24'h445566, '0, 128'b1111000, 0, 0);

      fill(0, 0, 9, 9, 24'h778899, '0, '0, 0, 15);
      fill(20, 30, 20, 30, 24'hCAFE00, '0, '0, 0, 0);

      for (int n = 0; n < 20; n++) begin
         x0 = $urandom_range(0, 3) == 0 ? $urandom_range(600, 1023) : $urandom_range(0, 639);
         y0 = $urandom_range(0, 3) == 0 ? $urandom_range(450, 511) : $urandom_range(0, 479);
         fill(x0, y0, x0 ^ $urandom_range(0, 7), y0 ^ $urandom_range(0, 7),
              24'($urandom), '0, '0, 1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
